// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two valid/ready requesters.
// Optional macro ALU_OP_CHECK_EN adds rsp*_err and answers illegal op codes without driving the ALU.
module alu_share_arbiter #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WORD_LEN-1:0] req0_a,
    input  logic [WORD_LEN-1:0] req0_b,
    input  logic [3:0]          req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WORD_LEN-1:0] req1_a,
    input  logic [WORD_LEN-1:0] req1_b,
    input  logic [3:0]          req1_op,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [WORD_LEN-1:0] rsp0_res,
    output logic                rsp0_zero,
    output logic                rsp0_ovf,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [WORD_LEN-1:0] rsp1_res,
    output logic                rsp1_zero,
    output logic                rsp1_ovf,
    output logic [WORD_LEN-1:0] alu_a,
    output logic [WORD_LEN-1:0] alu_b,
    output logic [3:0]          alu_op,
    input  logic [WORD_LEN-1:0] alu_res,
    input  logic                alu_zero,
    input  logic                alu_overflow,
`ifdef ALU_OP_CHECK_EN
    output logic                rsp0_err,
    output logic                rsp1_err,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    // Op code the ALU treats as "no operation" (res = 0); parked there outside EXEC.
    localparam logic [3:0] OP_NONE = 4'b1111;

    state_t              state;
    logic                prio;
    logic                grant;
    logic                sel;
    logic                accept;
    logic                rsp_take;
    logic [WORD_LEN-1:0] a_q, b_q, sel_a, sel_b;
    logic [3:0]          op_q, sel_op;
    logic [1:0]          rsp_valid_q, rsp_zero_q, rsp_ovf_q;
    logic [WORD_LEN-1:0] rsp_res_q [2];

    // With prio=1, req1 wins if valid; with prio=0, req1 wins only when req0 is idle.
    assign sel      = prio ? req1_valid : ~req0_valid;
    assign accept   = (state == IDLE) && (req0_valid || req1_valid);
    assign sel_a    = sel ? req1_a : req0_a;
    assign sel_b    = sel ? req1_b : req0_b;
    assign sel_op   = sel ? req1_op : req0_op;
    assign rsp_take = grant ? rsp1_ready : rsp0_ready;

    assign req0_ready = accept && !sel;
    assign req1_ready = accept && sel;
    assign busy       = (state != IDLE);

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp0_res   = rsp_res_q[0];
    assign rsp0_zero  = rsp_zero_q[0];
    assign rsp0_ovf   = rsp_ovf_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp1_res   = rsp_res_q[1];
    assign rsp1_zero  = rsp_zero_q[1];
    assign rsp1_ovf   = rsp_ovf_q[1];

`ifdef ALU_OP_CHECK_EN
    logic [1:0] rsp_err_q;
    assign rsp0_err = rsp_err_q[0];
    assign rsp1_err = rsp_err_q[1];

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    endfunction
`endif

    // NOTE: non-blocking assignments only, so every register samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prio        <= 1'b0;
            grant       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_NONE;
            rsp_valid_q <= '0;
            rsp_zero_q  <= '0;
            rsp_ovf_q   <= '0;
            // NOTE: the result array holds visible output registers, so it is reset like any other flop.
            rsp_res_q   <= '{default: '0};
`ifdef ALU_OP_CHECK_EN
            rsp_err_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant <= sel;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
`ifdef ALU_OP_CHECK_EN
                        if (!op_legal(sel_op)) begin
                            rsp_valid_q[sel] <= 1'b1;
                            rsp_res_q[sel]   <= '0;
                            rsp_zero_q[sel]  <= 1'b1;
                            rsp_ovf_q[sel]   <= 1'b0;
                            rsp_err_q[sel]   <= 1'b1;
                            state            <= HOLD;
                        end else begin
                            op_q  <= sel_op;
                            state <= EXEC;
                        end
`else
                        op_q  <= sel_op;
                        state <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    rsp_valid_q[grant] <= 1'b1;
                    rsp_res_q[grant]   <= alu_res;
                    rsp_zero_q[grant]  <= alu_zero;
                    rsp_ovf_q[grant]   <= alu_overflow;
`ifdef ALU_OP_CHECK_EN
                    rsp_err_q[grant]   <= 1'b0;
`endif
                    op_q               <= OP_NONE;
                    state              <= HOLD;
                end
                HOLD: begin
                    if (rsp_take) begin
                        rsp_valid_q[grant] <= 1'b0;
                        prio               <= ~grant;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table of single operations plus contention,
// backpressure, mid-operation reset and illegal-op sequences against a behavioural ALU.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100;
`ifdef ALU_OP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_ovf;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_ovf;
    logic [31:0] rsp0_res, rsp1_res;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_op;
    logic        alu_zero, alu_overflow, busy;
`ifdef ALU_OP_CHECK_EN
    logic        rsp0_err, rsp1_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WORD_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_res(rsp0_res), .rsp0_zero(rsp0_zero), .rsp0_ovf(rsp0_ovf),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_res(rsp1_res), .rsp1_zero(rsp1_zero), .rsp1_ovf(rsp1_ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
`ifdef ALU_OP_CHECK_EN
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
`endif
        .busy(busy)
    );

    // Behavioural stand-in for the external ALU.
    always_comb begin
        logic [32:0] diff;
        logic [31:0] r;
        diff         = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        r            = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            OP_AND: r = alu_a & alu_b;
            OP_OR:  r = alu_a | alu_b;
            OP_ADD: begin
                r = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (r[31] != alu_a[31]);
            end
            OP_SUB: begin
                r = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (r[31] != alu_a[31]);
            end
            OP_SLT: begin
                r = {31'd0, ($signed(alu_a) < $signed(alu_b))};
                alu_overflow = diff[32];
            end
            OP_NOR: r = ~(alu_a | alu_b);
            default: r = '0;
        endcase
        alu_res  = r;
        alu_zero = (r == '0);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        if (p == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
        else        begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) rsp0_ready = v;
        else        rsp1_ready = v;
    endtask

    function automatic logic f_ready(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction
    function automatic logic f_valid(input int p);
        return (p == 0) ? rsp0_valid : rsp1_valid;
    endfunction
    function automatic logic [31:0] f_res(input int p);
        return (p == 0) ? rsp0_res : rsp1_res;
    endfunction
    function automatic logic f_zero(input int p);
        return (p == 0) ? rsp0_zero : rsp1_zero;
    endfunction
    function automatic logic f_ovf(input int p);
        return (p == 0) ? rsp0_ovf : rsp1_ovf;
    endfunction

    // One operation on port p with nothing else in flight: handshake, latency, payload, consume.
    task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] er, input logic ez, input logic eo, input logic illegal);
        int n;
        @(negedge clk);
        set_req(p, 1'b1, a, b, op);
        #1;
        n = 0;
        while (!f_ready(p) && n < 20) begin @(negedge clk); #1; n++; end
        check("req_ready", f_ready(p), 1);
        @(negedge clk);
        set_req(p, 1'b0, '0, '0, '0);
        #1;
        check("busy_after_accept", busy, 1);
        check("alu_op_cycle1", alu_op, (illegal && CHK) ? 4'b1111 : op);
        n = 1;
        while (!f_valid(p) && n < 20) begin @(negedge clk); #1; n++; end
        check("latency", n, (illegal && CHK) ? 1 : 2);
        check("rsp_res", f_res(p), er);
        check("rsp_zero", f_zero(p), ez);
        check("rsp_ovf", f_ovf(p), eo);
        check("other_rsp_idle", f_valid(1 - p), 0);
        check("alu_op_hold", alu_op, 4'b1111);
`ifdef ALU_OP_CHECK_EN
        check("rsp_err", (p == 0) ? rsp0_err : rsp1_err, illegal);
`endif
        set_rsp_ready(p, 1'b1);
        @(negedge clk);
        set_rsp_ready(p, 1'b0);
        #1;
        check("rsp_valid_cleared", f_valid(p), 0);
        check("busy_idle", busy, 0);
    endtask

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        illegal;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int ng;
        int nr;
        int grants [4];
        logic [31:0] held;

        vecs[0] = '{0, 32'd5,        32'd7,        OP_ADD,  32'd12,       1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 32'h7FFFFFFF, 32'd1,        OP_ADD,  32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1, 32'h80000000, 32'd1,        OP_SUB,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{0, 32'hF0F00000, 32'h0FF000FF, OP_AND,  32'h00F00000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1, 32'hF0F00000, 32'h0FF000FF, OP_OR,   32'hFFF000FF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{0, 32'hFFFF0000, 32'h0000FFFF, OP_NOR,  32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1, 32'hFFFFFFFE, 32'd1,        OP_SLT,  32'd1,        1'b0, 1'b1, 1'b0};
        vecs[7] = '{0, 32'h12345678, 32'd9,        4'b0011, 32'd0,        1'b1, 1'b0, 1'b1};
        vecs[8] = '{1, 32'd5,        32'd5,        OP_SUB,  32'd0,        1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rsp0_valid", rsp0_valid, 0);
        check("reset_rsp1_valid", rsp1_valid, 0);
        check("reset_rsp0_res", rsp0_res, 0);
        check("reset_alu_op", alu_op, 4'b1111);
        check("reset_alu_a", alu_a, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("idle_no_ready", {req0_ready, req1_ready}, 2'b00);

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op,
                  vecs[i].res, vecs[i].zero, vecs[i].ovf, vecs[i].illegal);

        // Contention: both requesters always valid, responses consumed immediately.
        @(negedge clk);
        set_req(0, 1'b1, 32'h10, 32'h10, OP_SUB);
        set_req(1, 1'b1, 32'd3, 32'd9, OP_SLT);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 16; c++) begin
            if (rsp0_valid) begin
                check("cont_rsp0_res", rsp0_res, 0);
                check("cont_rsp0_zero", rsp0_zero, 1);
                nr++;
            end
            if (rsp1_valid) begin
                check("cont_rsp1_res", rsp1_res, 1);
                nr++;
            end
            if (ng < 4 && req0_valid && req0_ready) begin grants[ng] = 0; ng++; end
            else if (ng < 4 && req1_valid && req1_ready) begin grants[ng] = 1; ng++; end
            @(negedge clk);
            if (ng >= 4) begin
                set_req(0, 1'b0, '0, '0, '0);
                set_req(1, 1'b0, '0, '0, '0);
            end
            #1;
        end
        check("cont_grant_count", ng, 4);
        check("cont_rsp_count", nr, 4);
        for (int g = 0; g < 4; g++)
            if (g < ng) check("cont_grant_order", grants[g], g % 2);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Backpressure on rsp1 while req0 waits.
        @(negedge clk);
        set_req(1, 1'b1, 32'd3, 32'd9, OP_SLT);
        #1;
        n = 0;
        while (!req1_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("bp_req1_ready", req1_ready, 1);
        @(negedge clk);
        set_req(1, 1'b0, '0, '0, '0);
        set_req(0, 1'b1, 32'h0000F0F0, 32'h0000FF00, OP_AND);
        #1;
        n = 0;
        while (!rsp1_valid && n < 20) begin @(negedge clk); #1; n++; end
        held = rsp1_res;
        check("bp_rsp1_res", held, 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp1_valid_held", rsp1_valid, 1);
            check("bp_rsp1_res_stable", rsp1_res, held);
            check("bp_req0_blocked", req0_ready, 0);
            @(negedge clk);
            #1;
        end
        rsp1_ready = 1'b1;
        #1;
        check("bp_req0_blocked_last", req0_ready, 0);
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        check("bp_rsp1_released", rsp1_valid, 0);
        check("bp_req0_granted_next", req0_ready, 1);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, '0);
        #1;
        n = 0;
        while (!rsp0_valid && n < 20) begin @(negedge clk); #1; n++; end
        check("bp_rsp0_res", rsp0_res, 32'h0000F000);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;

        // Reset during EXEC of req1; prio is 1 at this point and must return to 0.
        @(negedge clk);
        set_req(1, 1'b1, 32'd9, 32'd3, OP_SUB);
        #1;
        n = 0;
        while (!req1_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("rst_req1_ready", req1_ready, 1);
        @(negedge clk);
        set_req(1, 1'b0, '0, '0, '0);
        #1;
        check("rst_in_exec", alu_op, OP_SUB);
        rst = 1'b1;
        #1;
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_alu_op", alu_op, 4'b1111);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_response", {rsp0_valid, rsp1_valid}, 2'b00);
        set_req(0, 1'b1, 32'd1, 32'd2, OP_OR);
        set_req(1, 1'b1, 32'd4, 32'd8, OP_OR);
        #1;
        check("rst_prio_req0", {req0_ready, req1_ready}, 2'b10);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        #1;
        n = 1;
        while (!rsp0_valid && n < 20) begin @(negedge clk); #1; n++; end
        check("rst_after_latency", n, 2);
        check("rst_after_res", rsp0_res, 32'd3);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
